// File: rtl/red_pitaya_dsp_summer.sv
// rtl/red_pitaya_dsp_summer.sv - masked N-source pipelined adder tree with per-channel saturation
// Double-buffered masks, sticky saturation flags and saturating event counters on the system bus.
module red_pitaya_dsp_summer #(
    parameter int N_SRC   = 16,
    parameter int LOG_SRC = 4,
    parameter int N_OUT   = 2,
    parameter int W       = 14
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [N_SRC*W-1:0]   src_i,
    output logic [N_OUT*W-1:0]   dat_o,
    output logic [N_OUT-1:0]     sat_o,
    input  logic [31:0]          sys_addr,
    input  logic [31:0]          sys_wdata,
    input  logic [3:0]           sys_sel,
    input  logic                 sys_wen,
    input  logic                 sys_ren,
    output logic [31:0]          sys_rdata,
    output logic                 sys_err,
    output logic                 sys_ack
);
    localparam int NP = 2**LOG_SRC;
    localparam int WI = W + LOG_SRC;
    localparam int NN = 2*NP - 1;

    logic [N_SRC-1:0]   r_mask_sh  [N_OUT];
    logic [N_SRC-1:0]   r_mask_act [N_OUT];
    logic [N_OUT-1:0]   r_flags;
    logic [31:0]        w_cnt      [N_OUT];
    logic [WI-1:0]      r_node     [N_OUT][NN];
    logic [WI-1:0]      w_leaf     [N_OUT][NP];
    logic [N_OUT-1:0]   w_ovf;
    logic [N_OUT*W-1:0] r_dat;
    logic [N_OUT-1:0]   r_sat;
    logic [31:0]        r_rdata;
    logic               r_ack;
    logic               r_err;
    logic [7:0]         w_addr;
    logic [N_OUT-1:0]   w_hit_mask;
    logic [N_OUT-1:0]   w_hit_cnt;
    logic               w_hit_commit;
    logic               w_hit_flags;
    logic               w_mapped;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_addr    = sys_addr[7:0];
    assign w_unused  = ^{sys_sel, sys_addr[31:8]};
    assign dat_o     = r_dat;
    assign sat_o     = r_sat;
    assign sys_rdata = r_rdata;
    assign sys_ack   = r_ack;
    assign sys_err   = r_err;

    // Leaves of a heap-ordered tree: node n has children 2n+1 and 2n+2, leaves start at NP-1.
    always_comb begin
        for (int c = 0; c < N_OUT; c++) begin
            for (int i = 0; i < NP; i++) begin
                w_leaf[c][i] = '0;
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (r_mask_act[c][i]) begin
                    w_leaf[c][i] = {{LOG_SRC{src_i[i*W+W-1]}}, src_i[i*W +: W]};
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < N_OUT; c++) begin
                for (int n = 0; n < NN; n++) begin
                    r_node[c][n] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < N_OUT; c++) begin
                for (int i = 0; i < NP; i++) begin
                    r_node[c][NP-1+i] <= w_leaf[c][i];
                end
                for (int n = 0; n < NP-1; n++) begin
                    r_node[c][n] <= r_node[c][2*n+1] + r_node[c][2*n+2];
                end
            end
        end
    end

    // The root fits in W bits only when all bits above the W-bit sign agree with it.
    always_comb begin
        for (int c = 0; c < N_OUT; c++) begin
            w_ovf[c] = (r_node[c][0][WI-1:W-1] != '0) && (r_node[c][0][WI-1:W-1] != '1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_dat <= '0;
            r_sat <= '0;
        end else begin
            for (int c = 0; c < N_OUT; c++) begin
                if (w_ovf[c]) begin
                    r_dat[c*W +: W] <= r_node[c][0][WI-1] ? {1'b1, {(W-1){1'b0}}}
                                                          : {1'b0, {(W-1){1'b1}}};
                end else begin
                    r_dat[c*W +: W] <= r_node[c][0][W-1:0];
                end
                r_sat[c] <= w_ovf[c];
            end
        end
    end

    always_comb begin
        w_hit_mask   = '0;
        w_hit_cnt    = '0;
        w_hit_commit = (w_addr == 8'h40);
        w_hit_flags  = (w_addr == 8'h44);
        for (int c = 0; c < N_OUT; c++) begin
            w_hit_mask[c] = (w_addr == 8'(4*c));
            w_hit_cnt[c]  = (w_addr == 8'(128 + 4*c));
        end
        w_mapped = w_hit_commit | w_hit_flags | (|w_hit_mask) | (|w_hit_cnt);
    end

    // A simultaneous write+read returns the value the write leaves behind.
    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < N_OUT; c++) begin
            if (w_hit_mask[c]) begin
                w_rdata = sys_wen ? 32'(sys_wdata[N_SRC-1:0]) : 32'(r_mask_sh[c]);
            end
            if (w_hit_cnt[c]) begin
                w_rdata = sys_wen ? 32'd0 : w_cnt[c];
            end
        end
        if (w_hit_flags) begin
            w_rdata = 32'(r_flags);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < N_OUT; c++) begin
                r_mask_sh[c]  <= '0;
                r_mask_act[c] <= '0;
            end
            r_flags <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            for (int c = 0; c < N_OUT; c++) begin
                if (sys_wen && w_hit_mask[c]) begin
                    r_mask_sh[c] <= sys_wdata[N_SRC-1:0];
                end
                if (sys_wen && w_hit_commit) begin
                    r_mask_act[c] <= r_mask_sh[c];
                end
            end
            r_flags <= ((sys_ren && w_hit_flags) ? '0 : r_flags) | r_sat;
            r_ack   <= sys_wen | sys_ren;
            r_err   <= (sys_wen | sys_ren) & ~w_mapped;
            r_rdata <= sys_ren ? w_rdata : '0;
        end
    end

    for (genvar c = 0; c < N_OUT; c++) begin : g_cnt
        logic [31:0] r_cnt;
        always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
                r_cnt <= '0;
            end else if (sys_wen && w_hit_cnt[c]) begin
                r_cnt <= '0;
            end else if (r_sat[c] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
        assign w_cnt[c] = r_cnt;
    end

endmodule

// File: tb/tb_red_pitaya_dsp_summer.sv
// tb/tb_red_pitaya_dsp_summer.sv - self-checking bench for red_pitaya_dsp_summer
module tb_red_pitaya_dsp_summer;
    localparam int N_SRC = 16, LOG_SRC = 4, N_OUT = 2, W = 14;
    localparam int LAT  = LOG_SRC + 2;
    localparam int SMAX = 2**(W-1) - 1;
    localparam int SMIN = -(2**(W-1));

    logic               clk = 1'b0;
    logic               rstn;
    logic [N_SRC*W-1:0] src;
    logic [N_OUT*W-1:0] dat;
    logic [N_OUT-1:0]   sat;
    logic [31:0]        addr, wdata, rdata;
    logic [3:0]         sel;
    logic               wen, ren, err, ack;
    int                 checks = 0;
    int                 errors = 0;
    bit                 chk_en = 0;

    typedef struct {
        logic [15:0] m0, m1;
        int s0, s1, s2, s3;
        int e0, e1;
        logic [1:0] es;
    } vec_t;
    vec_t vt [6];

    always #5 clk = ~clk;

    red_pitaya_dsp_summer #(.N_SRC(N_SRC), .LOG_SRC(LOG_SRC), .N_OUT(N_OUT), .W(W)) dut (
        .clk_i(clk), .rstn_i(rstn), .src_i(src), .dat_o(dat), .sat_o(sat),
        .sys_addr(addr), .sys_wdata(wdata), .sys_sel(sel), .sys_wen(wen), .sys_ren(ren),
        .sys_rdata(rdata), .sys_err(err), .sys_ack(ack)
    );

    // Reference: ideal integer sum of enabled sources, clamped, delayed by the pipeline latency.
    int               h_dat [LAT][N_OUT];
    bit               h_sat [LAT][N_OUT];
    logic [N_SRC-1:0] m_sh  [N_OUT];
    logic [N_SRC-1:0] m_act [N_OUT];

    always @(posedge clk) begin
        int sum;
        logic signed [W-1:0] sv;
        if (!rstn) begin
            for (int k = 0; k < LAT; k++)
                for (int c = 0; c < N_OUT; c++) begin
                    h_dat[k][c] = 0;
                    h_sat[k][c] = 0;
                end
            for (int c = 0; c < N_OUT; c++) begin
                m_sh[c]  = '0;
                m_act[c] = '0;
            end
        end else begin
            for (int k = LAT-1; k > 0; k--)
                for (int c = 0; c < N_OUT; c++) begin
                    h_dat[k][c] = h_dat[k-1][c];
                    h_sat[k][c] = h_sat[k-1][c];
                end
            for (int c = 0; c < N_OUT; c++) begin
                sum = 0;
                for (int s = 0; s < N_SRC; s++)
                    if (m_act[c][s]) begin
                        sv = src[s*W +: W];
                        sum += int'(sv);
                    end
                h_sat[0][c] = (sum > SMAX) || (sum < SMIN);
                h_dat[0][c] = (sum > SMAX) ? SMAX : (sum < SMIN) ? SMIN : sum;
            end
            if (wen) begin
                if (addr[7:0] == 8'h40)
                    for (int c = 0; c < N_OUT; c++) m_act[c] = m_sh[c];
                for (int c = 0; c < N_OUT; c++)
                    if (addr[7:0] == 8'(4*c)) m_sh[c] = wdata[N_SRC-1:0];
            end
        end
    end

    always @(negedge clk) begin
        int e;
        logic [W-1:0] ew;
        if (chk_en) begin
            for (int c = 0; c < N_OUT; c++) begin
                e  = h_dat[LAT-1][c];
                ew = e[W-1:0];
                checks++;
                if (dat[c*W +: W] !== ew) begin
                    errors++;
                    $display("FAIL model_dat ch%0d t=%0t got %0d want %0d", c, $time,
                             $signed(dat[c*W +: W]), e);
                end
                checks++;
                if (sat[c] !== h_sat[LAT-1][c]) begin
                    errors++;
                    $display("FAIL model_sat ch%0d t=%0t got %b want %b", c, $time, sat[c],
                             h_sat[LAT-1][c]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_dat(input string nm, input int c, input int e);
        logic [W-1:0] a;
        a = dat[c*W +: W];
        checks++;
        if (a !== e[W-1:0]) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, $signed(a), e);
        end
    endtask

    task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        @(negedge clk);
        addr = a; wdata = d; wen = w; ren = r;
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0;
        @(negedge clk);
        chk("ack", 32'(ack), 32'd1);
        rd = rdata;
        er = err;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic er;
        bus(1'b1, 1'b0, a, d, rd, er);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic er;
        bus(1'b0, 1'b1, a, 32'd0, rd, er);
        chk(nm, rd, exp);
        chk({nm, "_err"}, 32'(er), 32'd0);
    endtask

    task automatic set_src(input int s, input int v);
        src[s*W +: W] = v[W-1:0];
    endtask

    task automatic rand_src(input int shmax);
        int v;
        for (int s = 0; s < N_SRC; s++) begin
            v = int'($urandom_range(0, 2**W - 1)) + SMIN;
            v = v / (1 << $urandom_range(0, shmax));
            set_src(s, v);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          nz;

        vt[0] = '{16'h1, 16'h2, 100, 200, 0, 0, 100, 200, 2'b00};
        vt[1] = '{16'h3, 16'hC, -5000, -4000, 3000, 2000, -8192, 5000, 2'b01};
        vt[2] = '{16'hF, 16'h5, 8191, -8192, 1, 0, 0, 8191, 2'b10};
        vt[3] = '{16'h6, 16'h9, -8192, 0, 0, -1, 0, -8192, 2'b10};
        vt[4] = '{16'hF, 16'hF, 2000, 2000, 2000, 2191, 8191, 8191, 2'b00};
        vt[5] = '{16'h0, 16'hF, -2048, -2048, -2048, -2048, 0, -8192, 2'b00};

        rstn = 1'b0; src = '0; addr = '0; wdata = '0; sel = 4'hF; wen = 1'b0; ren = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_dat", 32'(dat), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rstn = 1'b1;

        nz = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dat !== '0) nz++;
            rand_src(0);
        end
        chk("nocommit_nonzero_cycles", 32'(nz), 32'd0);
        rd_chk("flags_rst", 32'h44, 32'd0);
        rd_chk("cnt0_rst", 32'h80, 32'd0);
        rd_chk("cnt1_rst", 32'h84, 32'd0);

        @(negedge clk);
        src = '0; set_src(0, 1000); set_src(1, -300);
        wr(32'h00, 32'h3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_dat("pre_commit", 0, 0);
        addr = 32'h40; wdata = 32'd0; wen = 1'b1;
        @(posedge clk);
        #1 wen = 1'b0;
        repeat (LAT-1) @(posedge clk);
        @(negedge clk);
        chk_dat("lat_t6", 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk_dat("lat_t7", 0, 700);
        rd_chk("mask0_rd", 32'h00, 32'h3);

        for (int v = 0; v < 6; v++) begin
            wr(32'h00, 32'(vt[v].m0));
            wr(32'h04, 32'(vt[v].m1));
            wr(32'h40, 32'd0);
            @(negedge clk);
            src = '0;
            set_src(0, vt[v].s0); set_src(1, vt[v].s1); set_src(2, vt[v].s2); set_src(3, vt[v].s3);
            repeat (LAT+2) @(posedge clk);
            @(negedge clk);
            chk_dat($sformatf("vec%0d_dat0", v), 0, vt[v].e0);
            chk_dat($sformatf("vec%0d_dat1", v), 1, vt[v].e1);
            chk($sformatf("vec%0d_sat", v), 32'(sat), 32'(vt[v].es));
        end

        @(negedge clk);
        src = '0;
        wr(32'h00, 32'h3); wr(32'h04, 32'hF); wr(32'h40, 32'd0);
        repeat (LAT+2) @(posedge clk);
        wr(32'h80, 32'd0); wr(32'h84, 32'd0);
        @(negedge clk);
        for (int s = 0; s < 4; s++) set_src(s, 8191);
        repeat (5) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) set_src(s, -8192);
        @(posedge clk);
        @(negedge clk);
        chk_dat("sat_pos_dat1", 1, 8191);
        chk("sat_pos_sat1", 32'(sat[1]), 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        src = '0;
        @(posedge clk);
        @(negedge clk);
        chk_dat("sat_neg_dat1", 1, -8192);
        chk("sat_neg_sat1", 32'(sat[1]), 32'd1);
        repeat (LAT+2) @(posedge clk);
        rd_chk("cnt1_10", 32'h84, 32'd10);
        rd_chk("cnt0_10", 32'h80, 32'd10);

        rd_chk("flags_both", 32'h44, 32'h3);
        rd_chk("flags_cleared", 32'h44, 32'h0);
        @(negedge clk);
        set_src(2, 8191); set_src(3, 8191);
        @(negedge clk);
        src = '0;
        repeat (LAT+2) @(posedge clk);
        rd_chk("flags_one", 32'h44, 32'h2);
        rd_chk("flags_one_clr", 32'h44, 32'h0);
        @(negedge clk);
        set_src(2, 8191); set_src(3, 8191);
        repeat (LAT+2) @(posedge clk);
        rd_chk("flags_hold_a", 32'h44, 32'h2);
        rd_chk("flags_hold_setwins", 32'h44, 32'h2);

        @(negedge clk);
        force dut.g_cnt[1].r_cnt = 32'hFFFF_FFFE;
        #1 release dut.g_cnt[1].r_cnt;
        repeat (5) @(posedge clk);
        @(negedge clk);
        src = '0;
        repeat (LAT+2) @(posedge clk);
        rd_chk("cnt1_limit", 32'h84, 32'hFFFF_FFFF);
        wr(32'h84, 32'h1234);
        rd_chk("cnt1_wclr", 32'h84, 32'd0);
        bus(1'b1, 1'b1, 32'h84, 32'h55, rd, er);
        chk("cnt1_wr_rd", rd, 32'd0);
        bus(1'b1, 1'b1, 32'h04, 32'hABCD_1234, rd, er);
        chk("mask1_wr_rd", rd, 32'h1234);
        rd_chk("commit_rd0", 32'h40, 32'd0);

        bus(1'b0, 1'b1, 32'h3C, 32'd0, rd, er);
        chk("unmap_rd_err", 32'(er), 32'd1);
        chk("unmap_rd_data", rd, 32'd0);
        bus(1'b1, 1'b0, 32'h08, 32'hFFFF, rd, er);
        chk("unmap_wr_err", 32'(er), 32'd1);
        rd_chk("mask0_after_unmap", 32'h00, 32'h3);

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            rand_src(4);
            wen = 1'b0;
            if (cyc % 40 == 0) begin
                addr = ($urandom_range(0, 1) != 0) ? 32'h4 : 32'h0;
                wdata = $urandom & $urandom;
                wen = 1'b1;
            end else if (cyc % 40 == 1) begin
                addr = 32'h40;
                wen = 1'b1;
            end
        end
        @(negedge clk);
        wen = 1'b0;

        wr(32'h00, 32'hFFFF); wr(32'h04, 32'hFFFF); wr(32'h40, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rand_src(0);
        end
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_dat", 32'(dat), 32'd0);
        chk("midrst_sat", 32'(sat), 32'd0);
        rstn = 1'b1;
        rand_src(0);
        rd_chk("midrst_mask0", 32'h00, 32'd0);
        rd_chk("midrst_mask1", 32'h04, 32'd0);
        rd_chk("midrst_flags", 32'h44, 32'd0);
        repeat (LAT+2) @(posedge clk);
        @(negedge clk);
        chk("midrst_dat_later", 32'(dat), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
